// File: rtl/ascon_pack.sv
// ascon_pack: shared FSM state encoding and round constants for the ASCON-128 control path
// Contents: type_fsm_state (11 controller states), ROUNDS_A (p^a round count),
//           ROUND_B_START (first round index of p^b), ROUND_LAST (final round index).
package ascon_pack;

    typedef enum logic [3:0] {
        IDLE,
        CONF_INIT,
        INIT,
        WAIT_AD,
        AD,
        WAIT_PT,
        PT,
        LAST_PT,
        FINAL,
        TAG,
        END
    } type_fsm_state;

    localparam int         ROUNDS_A      = 12;
    localparam logic [3:0] ROUND_B_START = 4'd6;
    localparam logic [3:0] ROUND_LAST    = 4'(ROUNDS_A - 1);

endpackage

// File: rtl/round_counter.sv
// round_counter: 4-bit round index register with synchronous load and count enable
// Ports: clock_i/resetb_i (async active-low), init_i loads load_i (wins over en_i),
//        en_i increments, count_o is the current round index.
module round_counter (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       init_i,
    input  logic [3:0] load_i,
    input  logic       en_i,
    output logic [3:0] count_o
);

    logic [3:0] r_count;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            r_count <= '0;
        else if (init_i)
            r_count <= load_i;
        else if (en_i)
            r_count <= r_count + 4'd1;
    end

    assign count_o = r_count;

endmodule

// File: rtl/ascon_fsm.sv
// ascon_fsm: control FSM sequencing permutation_xor through init, one AD block,
//            NB_PT_BLOCKS plaintext blocks, finalisation and tag output.
// Ports: clock_i, resetb_i (async active-low), start_i, data_valid_i / data_ack_o handshake,
//        round_o, state_mode_o, en_reg_state_o, en_xor_{key_begin,lsb,key_end,data}_o,
//        en_out_{cipher,tag}_o, cipher_valid_o (registered), tag_valid_o, busy_o.
// Build option: ASCON_DATA_STALL_EN makes injection cycles wait for data_valid_i;
//               without it every injection cycle proceeds unconditionally.
module ascon_fsm
    import ascon_pack::*;
#(
    parameter int NB_PT_BLOCKS = 3
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_ack_o,
    output logic [3:0] round_o,
    output logic       state_mode_o,
    output logic       en_reg_state_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_lsb_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_data_o,
    output logic       en_out_cipher_o,
    output logic       en_out_tag_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       busy_o
);

    localparam int            BW       = $clog2(NB_PT_BLOCKS + 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(NB_PT_BLOCKS - 1);

    type_fsm_state r_state, w_next;
    logic [BW-1:0] r_blk, w_blk_nxt;
    logic          r_cipher_valid;
    logic          w_go, w_last, w_init;
    logic [3:0]    w_load, w_round;

`ifdef ASCON_DATA_STALL_EN
    assign w_go = data_valid_i;
`else
    logic w_unused_valid;
    assign w_unused_valid = data_valid_i;
    assign w_go = 1'b1;
`endif

    assign w_last    = (w_round == ROUND_LAST);
    assign w_blk_nxt = r_blk + 1'b1;

    round_counter u_round (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .init_i   (w_init),
        .load_i   (w_load),
        .en_i     (en_reg_state_o),
        .count_o  (w_round)
    );

    always_comb begin
        w_next             = r_state;
        w_init             = 1'b0;
        w_load             = 4'd0;
        data_ack_o         = 1'b0;
        state_mode_o       = 1'b0;
        en_reg_state_o     = 1'b0;
        en_xor_key_begin_o = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_xor_key_end_o   = 1'b0;
        en_xor_data_o      = 1'b0;
        en_out_cipher_o    = 1'b0;
        en_out_tag_o       = 1'b0;
        tag_valid_o        = 1'b0;
        case (r_state)
            IDLE: begin
                w_init = 1'b1;
                if (start_i) w_next = CONF_INIT;
            end
            CONF_INIT: begin
                en_reg_state_o = 1'b1;
                w_next         = INIT;
            end
            INIT: begin
                state_mode_o     = 1'b1;
                en_reg_state_o   = 1'b1;
                en_xor_key_end_o = w_last;
                if (w_last) begin
                    w_init = 1'b1;
                    w_load = ROUND_B_START;
                    w_next = WAIT_AD;
                end
            end
            WAIT_AD, WAIT_PT: begin
                state_mode_o    = 1'b1;
                en_reg_state_o  = w_go;
                en_xor_data_o   = w_go;
                data_ack_o      = w_go;
                en_out_cipher_o = w_go && (r_state == WAIT_PT);
                if (w_go) w_next = (r_state == WAIT_AD) ? AD : PT;
            end
            AD: begin
                state_mode_o   = 1'b1;
                en_reg_state_o = 1'b1;
                en_xor_lsb_o   = w_last;
                if (w_last) begin
                    w_init = 1'b1;
                    w_load = ROUND_B_START;
                    w_next = (NB_PT_BLOCKS > 1) ? WAIT_PT : LAST_PT;
                end
            end
            PT: begin
                state_mode_o   = 1'b1;
                en_reg_state_o = 1'b1;
                if (w_last) begin
                    w_init = 1'b1;
                    w_load = ROUND_B_START;
                    w_next = (w_blk_nxt == BLK_LAST) ? LAST_PT : WAIT_PT;
                end
            end
            LAST_PT: begin
                // Last block is XORed and captured as cipher but the state register
                // holds; FINAL round 0 re-injects it together with the key.
                state_mode_o    = 1'b1;
                en_xor_data_o   = w_go;
                en_out_cipher_o = w_go;
                data_ack_o      = w_go;
                if (w_go) begin
                    w_init = 1'b1;
                    w_next = FINAL;
                end
            end
            FINAL: begin
                state_mode_o       = 1'b1;
                en_reg_state_o     = 1'b1;
                en_xor_data_o      = (w_round == 4'd0);
                en_xor_key_begin_o = (w_round == 4'd0);
                en_xor_key_end_o   = w_last;
                if (w_last) begin
                    w_init = 1'b1;
                    w_next = TAG;
                end
            end
            TAG: begin
                state_mode_o = 1'b1;
                en_out_tag_o = 1'b1;
                w_next       = END;
            end
            END: begin
                state_mode_o = 1'b1;
                tag_valid_o  = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state        <= IDLE;
            r_blk          <= '0;
            r_cipher_valid <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cipher_valid <= en_out_cipher_o;
            if (r_state == IDLE)
                r_blk <= '0;
            else if (r_state == PT && w_last)
                r_blk <= w_blk_nxt;
        end
    end

    assign round_o        = w_round;
    assign cipher_valid_o = r_cipher_valid;
    assign busy_o         = (r_state != IDLE);

endmodule

// File: doc/ascon_fsm.md
# ascon_fsm

Control FSM for the ASCON-128 encryption datapath. It sequences `permutation_xor` through initialisation, one associated-data block, `NB_PT_BLOCKS` plaintext blocks and finalisation. On every clock edge it drives the round index, state-mux select, register enable, the four XOR enables and the cipher/tag capture enables. It sits directly upstream of `permutation_xor` and exchanges a valid/ack handshake with the data source.

## Interface
- `NB_PT_BLOCKS`, default 3: number of 64-bit plaintext blocks, ≥1. The last block is already padded by the source.
- `clock_i` in 1: single clock, rising edge.
- `resetb_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: sampled in IDLE; starts one encryption.
- `data_valid_i` in 1: the source presents an AD/PT block on the datapath `data_i`.
- `data_ack_o` out 1: the block is consumed this cycle.
- `round_o` out 4: round index to the datapath.
- `state_mode_o` out 1: 0 selects external `state_i`, 1 selects the feedback state.
- `en_reg_state_o` out 1: state register write enable.
- `en_xor_key_begin_o` out 1: XOR enable.
- `en_xor_lsb_o` out 1: XOR enable.
- `en_xor_key_end_o` out 1: XOR enable.
- `en_xor_data_o` out 1: XOR enable.
- `en_out_cipher_o` out 1: capture enable for the cipher register.
- `en_out_tag_o` out 1: capture enable for the tag register.
- `cipher_valid_o` out 1: one-cycle pulse when the datapath `cipher_o` holds a new block.
- `tag_valid_o` out 1: one-cycle pulse when the datapath `tag_o` is valid.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- States: IDLE, CONF_INIT, INIT, WAIT_AD, AD, WAIT_PT, PT, LAST_PT, FINAL, TAG, END.
- The 4-bit round counter is loaded per state and increments every cycle in which `en_reg_state_o`=1.
- **IDLE.** All enables are 0. `start_i`=1 moves the FSM to CONF_INIT.
- **CONF_INIT (1 cycle).** `round_o`=0, `state_mode_o`=0, `en_reg_state_o`=1. Next state is INIT.
- **INIT.** Rounds 1..11 with `state_mode_o`=1. `en_xor_key_end_o`=1 at round 11. Next state is WAIT_AD.
- **WAIT_AD.** `round_o`=6.
  - `data_valid_i`=1: `en_xor_data_o`=1, `data_ack_o`=1, `en_reg_state_o`=1, then go to AD.
  - `data_valid_i`=0: all enables are 0, so the state register holds.
- **AD.** Rounds 7..11. `en_xor_lsb_o`=1 at round 11.
  - Next state is WAIT_PT if `NB_PT_BLOCKS`>1, otherwise LAST_PT.
- **WAIT_PT.** Same as WAIT_AD, with `en_out_cipher_o`=1 in the injection cycle. Next state is PT.
- **PT.** Rounds 7..11. At exit the block counter increments.
  - Next state is LAST_PT when the counter reaches `NB_PT_BLOCKS`-1, otherwise WAIT_PT.
- **LAST_PT.**
  - `data_valid_i`=1: `en_xor_data_o`=1, `en_out_cipher_o`=1, `data_ack_o`=1, `en_reg_state_o`=0. Next state is FINAL.
  - `data_valid_i`=0: the FSM stalls.
- **FINAL.** Rounds 0..11 with `en_reg_state_o`=1.
  - Round 0: `en_xor_data_o`=1 and `en_xor_key_begin_o`=1, re-injecting the held last block.
  - Round 11: `en_xor_key_end_o`=1.
- **TAG (1 cycle).** `en_out_tag_o`=1, `en_reg_state_o`=0. Next state is END.
- **END (1 cycle).** `tag_valid_o`=1. Next state is IDLE.
- `start_i` is ignored outside IDLE.
- `cipher_valid_o` is registered: it is high the cycle after any cycle with `en_out_cipher_o`=1.

## Timing
- **Reset.** Async assertion forces IDLE and clears the counters.
  - All outputs are 0, except `state_mode_o`=0 and `round_o`=0.
  - This applies mid-operation too: there is no resume.
- **Outputs.** Control outputs are combinational from state, counter and `data_valid_i`. They are valid before the edge that consumes them.
- **Latency with no stalls.** The edge sampling `start_i` is cycle 0.
  - Init: cycles 1–12.
  - AD: 6 cycles.
  - Each non-last PT block: 6 cycles.
  - LAST_PT: 1 cycle.
  - FINAL: 12 cycles.
  - TAG: 1 cycle.
  - For `NB_PT_BLOCKS`=3: TAG is cycle 44, `tag_valid_o` is high in cycle 45, and `busy_o` falls after cycle 45.
- **Stalls.** Each stall cycle adds exactly one cycle. During a stall `round_o` stays at 6 (WAIT_*) or the LAST_PT value.
- **Handshake.** `data_ack_o` is asserted only in injection cycles. At most one block is consumed per cycle.

## Configuration
- `ASCON_DATA_STALL_EN` defined: handshake stalls as described above.
- Undefined: `data_valid_i` is ignored and every injection cycle proceeds unconditionally.
  - `data_ack_o` still pulses.
  - Latency is fixed at the no-stall figures.

## Structure
- Add to `ascon_pack`:
  - `typedef enum logic [3:0] type_fsm_state`;
  - localparams `ROUNDS_A`=12, `ROUND_B_START`=6, `ROUND_LAST`=11.
- Sub-module `round_counter`: 4-bit counter with async reset, `init_i` with load value, and `en_i`.
- The block counter is inline, width `$clog2(NB_PT_BLOCKS+1)`.

## Test plan
- **Reset mid-operation.** Pulse `start_i`, then drop `resetb_i` during INIT round 5 → all outputs are 0 immediately and the FSM is IDLE. A new `start_i` restarts at CONF_INIT.
- **Stalls.** Hold `data_valid_i`=0 for 3 cycles in WAIT_AD and in LAST_PT (macro defined):
  - `en_reg_state_o`=0 throughout;
  - `round_o` frozen;
  - `tag_valid_o` delayed by exactly 6 cycles.
- **`NB_PT_BLOCKS`=1.** AD goes directly to LAST_PT. `tag_valid_o` is high at cycle 33.
- **Integration.** With `permutation_xor`, drive:
  - key 8a55114d1cb6a9a2be263d4d7aecaaff;
  - nonce 4ed0ec0b98c529b7c8cddf37bcd0284a;
  - AD 4120746f20428000;
  - P1 5244562061752054, P2 6927626172206365, P3 20736f6972203f80.
  - Required: C1..C3 and the tag equal the ASCON-128 software model. C3 is captured with state enable low.
